// File: rtl/cla32_addsub_pipe.sv
// Two-stage pipelined add/subtract unit built from 4-bit CLA groups.
// Ports: clk/rst (sync, active-high); in_valid/in_ready + a,b,cin,sub in;
//        out_valid/out_ready + result,cout,ovf out.

module cla_add #(
  parameter int N = 16
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co
);
  localparam int G = N / 4;

  logic [N-1:0] g, p, c;
  logic [G-1:0] gg, gp;
  logic [G:0]   gc;

  assign g = x & y;
  assign p = x ^ y;

  // Group generate/propagate, then group carries, then in-group carries.
  always_comb begin
    gg = '0;
    gp = '0;
    gc = '0;
    c  = '0;
    for (int k = 0; k < G; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (&p[4*k+2 +: 2] & g[4*k+1])
            | (&p[4*k+1 +: 3] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
    gc[0] = ci;
    for (int k = 0; k < G; k++) begin
      gc[k+1] = gg[k] | (gp[k] & gc[k]);
    end
    for (int k = 0; k < G; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1]
               | (p[4*k+1] & g[4*k])
               | (&p[4*k +: 2] & gc[k]);
      c[4*k+3] = g[4*k+2]
               | (p[4*k+2] & g[4*k+1])
               | (&p[4*k+1 +: 2] & g[4*k])
               | (&p[4*k +: 3] & gc[k]);
    end
  end

  assign s  = p ^ c;
  assign co = gc[G];
endmodule

module cla32_addsub_pipe #(
  parameter int WIDTH    = 32,
  parameter int LO_WIDTH = WIDTH / 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);
  localparam int HI_WIDTH = WIDTH - LO_WIDTH;

  logic [WIDTH-1:0]    bx;
  logic                ci;
  logic [LO_WIDTH-1:0] lo_sum;
  logic                lo_co;

  logic                s1_valid;
  logic [LO_WIDTH-1:0] s1_lo;
  logic                s1_c;
  logic [HI_WIDTH-1:0] s1_a_hi;
  logic [HI_WIDTH-1:0] s1_bx_hi;

  logic [HI_WIDTH-1:0] hi_sum;
  logic                hi_co;
  logic                hi_ovf;
  logic                s2_adv;
  logic                accept;

  // Subtract is a + ~b + 1; cin=1 turns that into a borrow-in.
  assign bx = sub ? ~b : b;
  assign ci = sub ^ cin;

  cla_add #(.N(LO_WIDTH)) u_lo (
    .x  (a[LO_WIDTH-1:0]),
    .y  (bx[LO_WIDTH-1:0]),
    .ci (ci),
    .s  (lo_sum),
    .co (lo_co)
  );

  cla_add #(.N(HI_WIDTH)) u_hi (
    .x  (s1_a_hi),
    .y  (s1_bx_hi),
    .ci (s1_c),
    .s  (hi_sum),
    .co (hi_co)
  );

  assign hi_ovf = (s1_a_hi[HI_WIDTH-1] == s1_bx_hi[HI_WIDTH-1])
                & (hi_sum[HI_WIDTH-1] != s1_a_hi[HI_WIDTH-1]);

  assign s2_adv   = s1_valid & (~out_valid | out_ready);
  assign in_ready = ~s1_valid | s2_adv;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_lo     <= '0;
      s1_c      <= 1'b0;
      s1_a_hi   <= '0;
      s1_bx_hi  <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_lo    <= lo_sum;
        s1_c     <= lo_co;
        s1_a_hi  <= a[WIDTH-1:LO_WIDTH];
        s1_bx_hi <= bx[WIDTH-1:LO_WIDTH];
      end else if (s2_adv) begin
        s1_valid <= 1'b0;
      end
      if (s2_adv) begin
        out_valid <= 1'b1;
        result    <= {hi_sum, s1_lo};
        cout      <= hi_co;
        ovf       <= hi_ovf;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_cla32_addsub_pipe.sv
// Directed + random bench for cla32_addsub_pipe.
// Scoreboard checks every delivered beat in order against a reference sum.

module tb_cla32_addsub_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        cout;
  logic        ovf;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] r;
    logic        c;
    logic        v;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  cla32_addsub_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .ovf       (ovf)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] x,
                                 input logic [31:0] y,
                                 input logic c,
                                 input logic s);
    exp_t        e;
    logic [31:0] yx;
    logic [32:0] t;
    yx  = s ? ~y : y;
    t   = {1'b0, x} + {1'b0, yx} + {32'd0, s ^ c};
    e.r = t[31:0];
    e.c = t[32];
    e.v = (x[31] == yx[31]) && (t[31] != x[31]);
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("sb_spurious", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          chk("sb_res", {32'd0, result}, {32'd0, e.r});
          chk("sb_cout", {63'd0, cout}, {63'd0, e.c});
          chk("sb_ovf", {63'd0, ovf}, {63'd0, e.v});
        end
      end
      if (in_valid && in_ready)
        q.push_back(model(a, b, cin, sub));
    end
  end

  task automatic send(input logic [31:0] x, input logic [31:0] y,
                      input logic c, input logic s);
    logic acc;
    int   n;
    in_valid = 1'b1;
    a = x; b = y; cin = c; sub = s;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 100);
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic run1(input string tag,
                      input logic [31:0] x, input logic [31:0] y,
                      input logic c, input logic s,
                      input logic [31:0] er, input logic ec,
                      input logic ev);
    out_ready = 1'b1;
    send(x, y, c, s);
    @(negedge clk);
    chk({tag, "_lat"}, {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    chk({tag, "_vld"}, {63'd0, out_valid}, 64'd1);
    chk({tag, "_res"}, {32'd0, result}, {32'd0, er});
    chk({tag, "_cout"}, {63'd0, cout}, {63'd0, ec});
    chk({tag, "_ovf"}, {63'd0, ovf}, {63'd0, ev});
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic acc;
    int   n;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ovalid", {63'd0, out_valid}, 64'd0);
    chk("rst_result", {32'd0, result}, 64'd0);
    chk("rst_cout", {63'd0, cout}, 64'd0);
    chk("rst_ovf", {63'd0, ovf}, 64'd0);
    chk("rst_iready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;

    run1("wrap", 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    run1("sub0", 32'h5, 32'h7, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
    run1("sub1", 32'h5, 32'h7, 1'b1, 1'b1, 32'hFFFFFFFD, 1'b0, 1'b0);
    run1("povf", 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
    run1("novf", 32'h80000000, 32'h1, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);

    // Backpressure: two beats fill the pipe, third waits.
    out_ready = 1'b0;
    in_valid = 1'b1; sub = 1'b0; cin = 1'b0;
    a = 32'd1; b = 32'd1;
    @(posedge clk); #1;
    a = 32'd2; b = 32'd2;
    @(posedge clk); #1;
    a = 32'd3; b = 32'd3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_iready", {63'd0, in_ready}, 64'd0);
      chk("bp_ovalid", {63'd0, out_valid}, 64'd1);
      chk("bp_hold", {32'd0, result}, 64'd2);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_r2", {32'd0, result}, 64'd2);
    chk("bp_iready1", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_r4", {32'd0, result}, 64'd4);
    chk("bp_v4", {63'd0, out_valid}, 64'd1);
    @(negedge clk);
    chk("bp_r6", {32'd0, result}, 64'd6);
    chk("bp_v6", {63'd0, out_valid}, 64'd1);
    @(negedge clk);
    chk("bp_empty", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;

    // Reset with two beats pending.
    out_ready = 1'b0;
    in_valid = 1'b1; a = 32'd10; b = 32'd20;
    @(posedge clk); #1;
    a = 32'd30;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_ovalid", {63'd0, out_valid}, 64'd0);
    chk("mrst_result", {32'd0, result}, 64'd0);
    chk("mrst_iready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    run1("xcarry", 32'h0000FFFF, 32'h1, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0);

    // Random sweep with random backpressure.
    for (int i = 0; i < 10000; i++) begin
      in_valid = 1'b1;
      a = $urandom; b = $urandom;
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
      n = 0;
      do begin
        out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1;
        n++;
      end while (!acc && n < 1000);
      if (!acc) chk("rand_timeout", 64'd0, 64'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
